// File: rtl/hold_request_arbiter.sv
// HOLD/HLDA sequencer that lends the 8088 system bus to two external masters,
// round-robin, with a bounded grant length and a CPU bus cycle between grants.
module hold_request_arbiter #(
  parameter int MAX_GRANT_CYCLES = 16,
  parameter int SETTLE_CYCLES    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic       HLDA,
  input  logic [1:0] req,
  output logic       HOLD,
  output logic [1:0] grant,
  output logic       grant_timeout,
  output logic       hlda_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HLDA,
    S_SETTLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [7:0] GRANT_LAST  = 8'(MAX_GRANT_CYCLES - 1);
  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic       winner_q, winner_d;
  logic       last_served_q, last_served_d;
  logic [2:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] grant_cnt_q, grant_cnt_d;
  logic       hold_q, hold_d;
  logic [1:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;
  logic       hlda_error_q, hlda_error_d;
  logic       tick;

  assign tick = cpu_clock_posedge;

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_served_d = last_served_q;
    settle_cnt_d  = settle_cnt_q;
    grant_cnt_d   = grant_cnt_q;
    hold_d        = hold_q;
    grant_d       = grant_q;
    timeout_d     = 1'b0;
    hlda_error_d  = hlda_error_q;

    case (state_q)
      S_IDLE: begin
        hold_d  = 1'b0;
        grant_d = 2'b00;
        if (tick && (req != 2'b00)) begin
          winner_d = (req == 2'b11) ? ~last_served_q : req[1];
          hold_d   = 1'b1;
          state_d  = S_WAIT_HLDA;
        end
      end

      S_WAIT_HLDA: begin
        if (tick && HLDA) begin
          if (!req[winner_q]) begin
            state_d = S_RELEASE;
          end else begin
            settle_cnt_d = SETTLE_LOAD;
            state_d      = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        // The tick that saw HLDA counts as the first settle clock.
        if (tick) begin
          if (!HLDA || !req[winner_q]) begin
            state_d = S_RELEASE;
          end else if (settle_cnt_q <= 3'd1) begin
            grant_d       = winner_q ? 2'b10 : 2'b01;
            grant_cnt_d   = 8'd0;
            last_served_d = winner_q;
            state_d       = S_GRANT;
          end else begin
            settle_cnt_d = settle_cnt_q - 3'd1;
          end
        end
      end

      S_GRANT: begin
        if (tick) begin
          if (grant_cnt_q != 8'hFF) begin
            grant_cnt_d = grant_cnt_q + 8'd1;
          end
          if (!HLDA) begin
            grant_d      = 2'b00;
            hlda_error_d = 1'b1;
            hold_d       = 1'b0;
            state_d      = S_IDLE;
          end else if (!req[winner_q]) begin
            grant_d = 2'b00;
            state_d = S_RELEASE;
          end else if (grant_cnt_q == GRANT_LAST) begin
            grant_d   = 2'b00;
            timeout_d = 1'b1;
            state_d   = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        grant_d = 2'b00;
        if (cpu_clock_negedge) begin
          hold_d = 1'b0;
        end
        if (tick && !HLDA) begin
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      winner_q      <= 1'b0;
      last_served_q <= 1'b1;
      settle_cnt_q  <= 3'd0;
      grant_cnt_q   <= 8'd0;
      hold_q        <= 1'b0;
      grant_q       <= 2'b00;
      timeout_q     <= 1'b0;
      hlda_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_served_q <= last_served_d;
      settle_cnt_q  <= settle_cnt_d;
      grant_cnt_q   <= grant_cnt_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      timeout_q     <= timeout_d;
      hlda_error_q  <= hlda_error_d;
    end
  end

  assign HOLD          = hold_q;
  assign grant         = grant_q;
  assign grant_timeout = timeout_q;
  assign hlda_error    = hlda_error_q;

endmodule

// File: tb/tb_hold_request_arbiter.sv
// Scoreboard bench: stimulus queues each expected output change with the clock
// count at which it must appear; a negedge monitor pops and compares on change.
module tb_hold_request_arbiter;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       pos_en = 1'b1;
  logic       neg_en = 1'b0;
  logic       HLDA   = 1'b0;
  logic [1:0] req    = 2'b00;
  logic       HOLD;
  logic [1:0] grant;
  logic       grant_timeout;
  logic       hlda_error;
  logic [4:0] out_v;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] v;
    int         c;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_mon;
  logic [4:0] prev_v = 5'b0;

  hold_request_arbiter #(
    .MAX_GRANT_CYCLES(16),
    .SETTLE_CYCLES(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_clock_posedge(pos_en),
    .cpu_clock_negedge(neg_en),
    .HLDA(HLDA),
    .req(req),
    .HOLD(HOLD),
    .grant(grant),
    .grant_timeout(grant_timeout),
    .hlda_error(hlda_error)
  );

  assign out_v = {HOLD, grant, grant_timeout, hlda_error};

  always #5 clock = ~clock;

  // CPU clock = 4 system clocks; tick edges leave cyc%4==1, negedge-enable edges cyc%4==3.
  always @(posedge clock) begin
    cyc    <= cyc + 1;
    pos_en <= ((cyc + 1) % 4 == 0);
    neg_en <= ((cyc + 1) % 4 == 2);
  end

  function automatic logic [4:0] mk(logic h, logic [1:0] g, logic t, logic e);
    return {h, g, t, e};
  endfunction

  task automatic expect_at(string n, logic [4:0] v, int c);
    exp_t e;
    e.v = v;
    e.c = c;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic at(int t);
    while (cyc < t) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (out_v !== prev_v) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected: got {HOLD,grant,to,err}=%b at cyc %0d, required no change", out_v, cyc);
      end else begin
        e_mon = sb.pop_front();
        if (out_v !== e_mon.v || cyc != e_mon.c) begin
          bad++;
          $display("FAIL %s: got %b at cyc %0d, required %b at cyc %0d",
                   e_mon.name, out_v, cyc, e_mon.v, e_mon.c);
        end else begin
          $display("ok %s: {HOLD,grant,to,err}=%b at cyc %0d", e_mon.name, out_v, cyc);
        end
      end
      prev_v = out_v;
    end
    if (grant != 2'b00) begin
      total++;
      if (!HOLD) begin
        bad++;
        $display("FAIL grant_without_hold: got grant=%b HOLD=%b, required HOLD=1", grant, HOLD);
      end
    end
  end

  initial begin
    int b;
    #1 reset = 1'b1;
    #1;
    total++;
    if (out_v !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: got %b, required 00000", out_v);
    end
    at(6);
    reset = 1'b0;

    // Simultaneous requests from reset: master 0, then master 1, then master 0.
    b = 9;
    at(b);      req = 2'b11;  expect_at("rr_hold0", mk(1, 2'b00, 0, 0), b + 4);
    at(b + 4);  HLDA = 1'b1;  expect_at("rr_grant0", mk(1, 2'b01, 0, 0), b + 12);
    at(b + 12); req = 2'b10;  expect_at("rr_rel0", mk(1, 2'b00, 0, 0), b + 16);
                              expect_at("rr_drop0", mk(0, 2'b00, 0, 0), b + 18);
    at(b + 20); HLDA = 1'b0;  expect_at("rr_hold1", mk(1, 2'b00, 0, 0), b + 28);
    at(b + 28); HLDA = 1'b1;  expect_at("rr_grant1", mk(1, 2'b10, 0, 0), b + 36);
    at(b + 36); req = 2'b00;  expect_at("rr_rel1", mk(1, 2'b00, 0, 0), b + 40);
                              expect_at("rr_drop1", mk(0, 2'b00, 0, 0), b + 42);
    at(b + 44); HLDA = 1'b0;
    at(b + 48); req = 2'b11;  expect_at("rr_hold2", mk(1, 2'b00, 0, 0), b + 52);
    at(b + 52); HLDA = 1'b1;  expect_at("rr_grant2", mk(1, 2'b01, 0, 0), b + 60);
    at(b + 60); req = 2'b00;  expect_at("rr_rel2", mk(1, 2'b00, 0, 0), b + 64);
                              expect_at("rr_drop2", mk(0, 2'b00, 0, 0), b + 66);
    at(b + 68); HLDA = 1'b0;

    // Single request, HLDA two ticks after HOLD.
    b = b + 76;
    at(b);      req = 2'b01;  expect_at("single_hold", mk(1, 2'b00, 0, 0), b + 4);
    at(b + 8);  HLDA = 1'b1;  expect_at("single_grant", mk(1, 2'b01, 0, 0), b + 16);
    at(b + 16); req = 2'b00;  expect_at("single_rel", mk(1, 2'b00, 0, 0), b + 20);
                              expect_at("single_drop", mk(0, 2'b00, 0, 0), b + 22);
    at(b + 24); HLDA = 1'b0;

    // Watchdog: 16-tick grant, timeout pulse, re-grant only after HLDA cycles.
    b = b + 32;
    at(b);      req = 2'b01;  expect_at("wd_hold", mk(1, 2'b00, 0, 0), b + 4);
    at(b + 4);  HLDA = 1'b1;  expect_at("wd_grant", mk(1, 2'b01, 0, 0), b + 12);
                              expect_at("wd_timeout", mk(1, 2'b00, 1, 0), b + 76);
                              expect_at("wd_pulse_end", mk(1, 2'b00, 0, 0), b + 77);
                              expect_at("wd_drop", mk(0, 2'b00, 0, 0), b + 78);
    at(b + 80); HLDA = 1'b0;  expect_at("wd_rehold", mk(1, 2'b00, 0, 0), b + 88);
    at(b + 88); HLDA = 1'b1;  expect_at("wd_regrant", mk(1, 2'b01, 0, 0), b + 96);
    at(b + 96); req = 2'b00;  expect_at("wd_rel", mk(1, 2'b00, 0, 0), b + 100);
                              expect_at("wd_drop2", mk(0, 2'b00, 0, 0), b + 102);
    at(b + 104); HLDA = 1'b0;

    // Request withdrawn in WAIT_HLDA, then HLDA loss on master 1, then async reset.
    b = b + 112;
    at(b);      req = 2'b01;  expect_at("wd_wait_hold", mk(1, 2'b00, 0, 0), b + 4);
    at(b + 4);  req = 2'b00;
    at(b + 8);  HLDA = 1'b1;  expect_at("withdraw_drop", mk(0, 2'b00, 0, 0), b + 14);
    at(b + 16); HLDA = 1'b0;
    at(b + 24); req = 2'b10;  expect_at("loss_hold", mk(1, 2'b00, 0, 0), b + 28);
    at(b + 28); HLDA = 1'b1;  expect_at("loss_grant1", mk(1, 2'b10, 0, 0), b + 36);
    at(b + 40); HLDA = 1'b0;  expect_at("loss_error", mk(0, 2'b00, 0, 1), b + 44);
    at(b + 44); req = 2'b00;
    at(b + 48); req = 2'b01;  expect_at("sticky_hold", mk(1, 2'b00, 0, 1), b + 52);
    at(b + 52); HLDA = 1'b1;  expect_at("sticky_grant", mk(1, 2'b01, 0, 1), b + 60);
    at(b + 62);               expect_at("async_reset", mk(0, 2'b00, 0, 0), b + 63);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_v !== 5'b0) begin
      bad++;
      $display("FAIL async_reset_now: got %b, required 00000", out_v);
    end
    HLDA = 1'b0;
    req  = 2'b00;
    at(b + 66); reset = 1'b0;
    at(b + 68); req = 2'b11;  expect_at("post_rst_hold", mk(1, 2'b00, 0, 0), b + 72);
    at(b + 72); HLDA = 1'b1;  expect_at("post_rst_grant0", mk(1, 2'b01, 0, 0), b + 80);
    at(b + 80); req = 2'b00;  expect_at("post_rst_rel", mk(1, 2'b00, 0, 0), b + 84);
                              expect_at("post_rst_drop", mk(0, 2'b00, 0, 0), b + 86);
    at(b + 88); HLDA = 1'b0;
    at(b + 100);

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: got no change, required %b at cyc %0d", e.name, e.v, e.c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
